mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 ADDRW, default 32, CPU/host byte-address width.
REQ-002 INW, default 512, line width in bits (64 bytes).
REQ-003 INSTR_LIMIT, default 32'h0000_1000, addresses below this are instruction fetches; all others are data.
REQ-004 AUDIO_BASE, default 32'h0010_0000, first host byte address of the audio ring.
REQ-005 AUDIO_LINES, default 256, audio ring depth in lines (power of two).
REQ-006 TIMEOUT, default 1024, maximum host wait cycles per transaction.

Interface
REQ-007 The block SHALL have one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 op  in  2  CPU request: 00 idle, 01 read line, 10/11 ignored.
REQ-011 mem_address  in  ADDRW  CPU request byte address.
REQ-012 audio_valid  in  1  audio line available from CPU writeback.
REQ-013 audio_out  in  INW  audio line data.
REQ-014 common_data_bus_in  out  INW  returned line, held stable until the next delivery.
REQ-015 instr_write_en  out  1  one-cycle strobe: bus holds an instruction line.
REQ-016 mem_write_en  out  1  one-cycle strobe: bus holds a data line.
REQ-017 host_rd_req/host_rd_addr  out  1/ADDRW  host read request, line-aligned address.
REQ-018 host_rd_valid/host_rd_data  in  1/INW  host read response.
REQ-019 host_wr_req/host_wr_addr/host_wr_data  out  1/ADDRW/INW  host write request.
REQ-020 host_wr_ack  in  1  host write accepted.
REQ-021 tx_done  out  1  one-cycle pulse when an audio line write is acknowledged.
REQ-022 busy, err_timeout, audio_overflow  out  1 each  status; error flags sticky until rst.

Function
REQ-023 FSM states: IDLE, RD_WAIT, DELIVER, COOLDOWN, WR_WAIT.
REQ-024 Host address = {addr[ADDRW-1:6], 6'b0}; low six bits ignored.
REQ-025 IDLE, op==01: latch address, assert host_rd_req, go RD_WAIT; a read takes priority over a buffered audio write.
REQ-026 host_rd_req and host_rd_addr SHALL stay asserted and stable through RD_WAIT until host_rd_valid.
REQ-027 RD_WAIT with host_rd_valid: capture host_rd_data, drop host_rd_req, go DELIVER.
REQ-028 DELIVER: drive the captured line; pulse instr_write_en if the latched address < INSTR_LIMIT, else mem_write_en; never both; go COOLDOWN.
REQ-029 COOLDOWN: one cycle, op ignored (this suppresses a duplicate request while the CPU stall clears), then IDLE.
REQ-030 Read latency: op sampled at cycle N, host_rd_valid at cycle N+k, strobe at N+k+1.
REQ-031 Audio buffer: one entry; audio_valid with the buffer empty latches audio_out; audio_valid with the buffer full drops the line and sets audio_overflow.
REQ-032 IDLE, op!=01 and buffer full: assert host_wr_req with the ring address, go WR_WAIT.
REQ-033 WR_WAIT with host_wr_ack: drop host_wr_req, free the buffer, pulse tx_done, advance the ring pointer by 64 bytes (wrapping at AUDIO_LINES), go IDLE.
REQ-034 A buffer freed in the same cycle audio_valid arrives SHALL accept the new line, with no overflow.
REQ-035 Wait counter clears on entry to RD_WAIT/WR_WAIT; reaching TIMEOUT sets err_timeout, drops the request, goes IDLE with no strobe; an aborted write keeps its buffer for retry.
REQ-036 busy = (state != IDLE).

Reset
REQ-037 rst SHALL force IDLE, clear all strobes, requests, flags, buffer, bus, counters and ring pointer, and abort any transaction in flight.

Verification
REQ-038 op=01, addr=0x0000_0044, host_rd_valid 3 cycles later with data D -> host_rd_addr=0x40; instr_write_en pulses 1 cycle after valid; bus=D.
REQ-039 op=01, addr=0x0000_2000 -> mem_write_en only; op held high through COOLDOWN -> exactly one host_rd_req.
REQ-040 Audio: 257 lines, each acked -> addresses 0x100000..0x103FC0, then wrap to 0x100000; 257 tx_done pulses.
REQ-041 Two audio_valid pulses with no ack -> second line dropped, audio_overflow=1 and sticky.
REQ-042 No host_rd_valid for 1024 cycles -> err_timeout=1, host_rd_req=0, state IDLE, no strobe.
REQ-043 rst asserted in RD_WAIT -> next cycle all outputs 0, busy=0; a late host_rd_valid produces no strobe.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Serves CPU line reads from a host port and drains a one-entry
//                audio writeback buffer into a host-side ring.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
   parameter int unsigned             ADDRW       = 32,
   parameter int unsigned             INW         = 512,
   parameter logic [ADDRW-1:0]        INSTR_LIMIT = 'h0000_1000,
   parameter logic [ADDRW-1:0]        AUDIO_BASE  = 'h0010_0000,
   parameter int unsigned             AUDIO_LINES = 256,
   parameter int unsigned             TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op,
   input  logic [ADDRW-1:0] mem_address,
   input  logic             audio_valid,
   input  logic [INW-1:0]   audio_out,
   output logic [INW-1:0]   common_data_bus_in,
   output logic             instr_write_en,
   output logic             mem_write_en,
   output logic             host_rd_req,
   output logic [ADDRW-1:0] host_rd_addr,
   input  logic             host_rd_valid,
   input  logic [INW-1:0]   host_rd_data,
   output logic             host_wr_req,
   output logic [ADDRW-1:0] host_wr_addr,
   output logic [INW-1:0]   host_wr_data,
   input  logic             host_wr_ack,
   output logic             tx_done,
   output logic             busy,
   output logic             err_timeout,
   output logic             audio_overflow
);

   localparam int unsigned c_PTR_W = $clog2(AUDIO_LINES);
   localparam int unsigned c_CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      DELIVER  = 3'd2,
      COOLDOWN = 3'd3,
      WR_WAIT  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDRW-1:0]     r_addr;
   logic                 r_is_instr;
   logic [INW-1:0]       r_bus;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_PTR_W-1:0]   r_ptr;
   logic                 r_abuf_full;
   logic [INW-1:0]       r_abuf_data;
   logic                 r_tx_done;
   logic                 r_err_timeout;
   logic                 r_overflow;

   logic                 w_rd_start;
   logic                 w_rd_cap;
   logic                 w_wr_done;
   logic                 w_timeout;
   logic                 w_cnt_last;
   logic [ADDRW-1:0]     w_ring_addr;

   assign w_rd_start  = (op == 2'b01);
   assign w_cnt_last  = (r_cnt == c_CNT_W'(TIMEOUT - 1));
   // Ring pointer counts lines; the power-of-two depth gives a free wrap.
   assign w_ring_addr = AUDIO_BASE + ADDRW'({r_ptr, 6'b000000});

   always_comb begin
      w_state_nxt = r_state;
      w_rd_cap    = 1'b0;
      w_wr_done   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rd_start)       w_state_nxt = RD_WAIT;
            else if (r_abuf_full) w_state_nxt = WR_WAIT;
         end
         RD_WAIT: begin
            if (host_rd_valid) begin
               w_state_nxt = DELIVER;
               w_rd_cap    = 1'b1;
            end else if (w_cnt_last) begin
               w_state_nxt = IDLE;
               w_timeout   = 1'b1;
            end
         end
         DELIVER:  w_state_nxt = COOLDOWN;
         COOLDOWN: w_state_nxt = IDLE;
         WR_WAIT: begin
            if (host_wr_ack) begin
               w_state_nxt = IDLE;
               w_wr_done   = 1'b1;
            end else if (w_cnt_last) begin
               w_state_nxt = IDLE;
               w_timeout   = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_is_instr    <= 1'b0;
         r_bus         <= '0;
         r_cnt         <= '0;
         r_ptr         <= '0;
         r_abuf_full   <= 1'b0;
         r_abuf_data   <= '0;
         r_tx_done     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tx_done <= w_wr_done;
         if (r_state == IDLE && w_rd_start) begin
            r_addr     <= mem_address;
            r_is_instr <= (mem_address < INSTR_LIMIT);
         end
         if (w_rd_cap) r_bus <= host_rd_data;
         if (r_state == RD_WAIT || r_state == WR_WAIT) r_cnt <= r_cnt + 1'b1;
         else                                          r_cnt <= '0;
         if (w_timeout) r_err_timeout <= 1'b1;
         if (w_wr_done) begin
            r_abuf_full <= 1'b0;
            r_ptr       <= r_ptr + 1'b1;
         end
         // A slot freed this very cycle may be refilled without overflow.
         if (audio_valid) begin
            if (!r_abuf_full || w_wr_done) begin
               r_abuf_data <= audio_out;
               r_abuf_full <= 1'b1;
            end else begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   assign common_data_bus_in = r_bus;
   assign instr_write_en     = (r_state == DELIVER) &&  r_is_instr;
   assign mem_write_en       = (r_state == DELIVER) && !r_is_instr;
   assign host_rd_req        = (r_state == RD_WAIT);
   assign host_rd_addr       = {r_addr[ADDRW-1:6], 6'b000000};
   assign host_wr_req        = (r_state == WR_WAIT);
   assign host_wr_addr       = host_wr_req ? w_ring_addr : '0;
   assign host_wr_data       = host_wr_req ? r_abuf_data : '0;
   assign tx_done            = r_tx_done;
   assign busy               = (r_state != IDLE);
   assign err_timeout        = r_err_timeout;
   assign audio_overflow     = r_overflow;

endmodule
`default_nettype wire
